// File: rtl/iter_exe_unit.sv
// Multi-cycle execute unit.
// Single-cycle ALU commands finish one cycle after start.
// MUL/MULU use a radix-2 shift-add loop and DIV/DIVU use a restoring divide
// loop; each loop produces one bit per cycle for WIDTH cycles.
module iter_exe_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MULT, DIVD} state_t;

  state_t           state_reg, state_next;
  logic [SHW-1:0]   cnt_reg;
  logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg, opb_reg, a_orig_reg;
  logic             neg_q_reg, neg_r_reg, dz_reg;
  logic [WIDTH-1:0] result_reg, result_hi_reg;
  logic             done_reg, dbz_reg;

  logic             accept_iter, last_iter;
  logic             sgn, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] alu_result;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
  logic [2*WIDTH-1:0] prod_mag, prod_final;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_next, div_lo_next, div_q, div_r;

  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign result      = result_reg;
  assign result_hi   = result_hi_reg;
  assign div_by_zero = dbz_reg;
  assign last_iter   = (cnt_reg == SHW'(WIDTH - 1));

  // Operand preparation: sign extraction and magnitudes for signed commands
  always_comb begin
    sgn   = ~exe_cmd[0];
    sa    = sgn & val1[WIDTH-1];
    sb    = sgn & val2[WIDTH-1];
    mag_a = sa ? (~val1 + 1'b1) : val1;
    mag_b = sb ? (~val2 + 1'b1) : val2;
  end

  // Single-cycle ALU; reserved encodings fall through to zero
  always_comb begin
    alu_result = '0;
    shamt      = val2[SHW-1:0];
    case (exe_cmd)
      4'b0000: alu_result = val1 + val2;
      4'b0010: alu_result = val1 - val2;
      4'b0100: alu_result = val1 & val2;
      4'b0101: alu_result = val1 | val2;
      4'b0110: alu_result = ~(val1 | val2);
      4'b0111: alu_result = val1 ^ val2;
      4'b1000: alu_result = val1 << shamt;
      4'b1001: alu_result = $unsigned($signed(val1) >>> shamt);
      4'b1010: alu_result = val1 >> shamt;
      default: alu_result = '0;
    endcase
  end

  // One shift-add multiply step and one restoring divide step, plus final sign fix-up
  always_comb begin
    mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opb_reg} : {(WIDTH+1){1'b0}});
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
    prod_mag    = {mul_hi_next, mul_lo_next};
    prod_final  = neg_q_reg ? (~prod_mag + 1'b1) : prod_mag;

    // Partial remainder stays below the divisor, so a negative difference shows in bit WIDTH
    div_shift   = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    div_diff    = div_shift - {1'b0, opb_reg};
    div_ge      = ~div_diff[WIDTH];
    div_hi_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_next = {acc_lo_reg[WIDTH-2:0], div_ge};
    if (dz_reg) begin
      div_q = '1;
      div_r = a_orig_reg;
    end else begin
      div_q = neg_q_reg ? (~div_lo_next + 1'b1) : div_lo_next;
      div_r = neg_r_reg ? (~div_hi_next + 1'b1) : div_hi_next;
    end
  end

  // Next-state logic: iterative commands leave IDLE, loops return after WIDTH steps
  always_comb begin
    state_next  = state_reg;
    accept_iter = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && (exe_cmd[3:2] == 2'b11)) begin
          accept_iter = 1'b1;
          state_next  = exe_cmd[1] ? DIVD : MULT;
        end
      end
      MULT, DIVD: begin
        if (last_iter) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Datapath: operand latch, iteration registers and held outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg       <= '0;
      acc_hi_reg    <= '0;
      acc_lo_reg    <= '0;
      opb_reg       <= '0;
      a_orig_reg    <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      dz_reg        <= 1'b0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept_iter) begin
            acc_hi_reg <= '0;
            acc_lo_reg <= mag_a;
            opb_reg    <= mag_b;
            cnt_reg    <= '0;
            neg_q_reg  <= sa ^ sb;
            neg_r_reg  <= sa;
            dz_reg     <= exe_cmd[1] && (val2 == '0);
            a_orig_reg <= val1;
          end else if (start) begin
            result_reg    <= alu_result;
            result_hi_reg <= '0;
            dbz_reg       <= 1'b0;
            done_reg      <= 1'b1;
          end
        end
        MULT: begin
          acc_hi_reg <= mul_hi_next;
          acc_lo_reg <= mul_lo_next;
          cnt_reg    <= cnt_reg + SHW'(1);
          if (last_iter) begin
            result_reg    <= prod_final[WIDTH-1:0];
            result_hi_reg <= prod_final[2*WIDTH-1:WIDTH];
            dbz_reg       <= 1'b0;
            done_reg      <= 1'b1;
          end
        end
        DIVD: begin
          acc_hi_reg <= div_hi_next;
          acc_lo_reg <= div_lo_next;
          cnt_reg    <= cnt_reg + SHW'(1);
          if (last_iter) begin
            result_reg    <= div_q;
            result_hi_reg <= div_r;
            dbz_reg       <= dz_reg;
            done_reg      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/iter_exe_unit.md
Name: iter_exe_unit

Overview:
- Parametrised multi-cycle execute unit; successor to the single-cycle combinational ALU.
- Keeps every existing EXE_CMD encoding, computed in 1 cycle.
- Adds iterative signed/unsigned multiply and divide, a start/busy/done handshake, and a high-word output.
- Sits in the EXE stage; the hazard unit stalls the pipeline while busy=1.

Parameters:
- WIDTH, 32, datapath width. Power of two, >=8.
- SHW, $clog2(WIDTH), derived (localparam); shift-amount bits taken from val2.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- start  input  1  request; accepted only when busy=0
- exe_cmd  input  4  operation, sampled on accept
- val1  input  WIDTH  operand A, sampled on accept
- val2  input  WIDTH  operand B, sampled on accept
- busy  output  1  iterative op in progress
- done  output  1  one-cycle pulse; result/result_hi valid from this cycle
- result  output  WIDTH  low result / product low / quotient
- result_hi  output  WIDTH  product high / remainder; 0 for single-cycle ops
- div_by_zero  output  1  set with done for DIV/DIVU with val2=0, else 0

Behaviour:
- Reset: rst=0 at a rising edge sets state=IDLE and clears busy, done, result, result_hi, div_by_zero and all internal registers.
  - Reset mid-operation aborts the op; no done is produced.
- Encodings:
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR, 1000 SLL, 1001 SRA, 1010 SRL: single-cycle.
  - 1100 MUL (signed), 1101 MULU, 1110 DIV (signed), 1111 DIVU: iterative.
  - 0001, 0011, 1011: single-cycle, result=0.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH.
- Shifts: amount = val2[SHW-1:0], upper bits ignored. SRA sign-fills; SRL/SLL zero-fill.
- States:
  - IDLE: busy=0.
    - start=1 with a single-cycle cmd: result registered at the edge; done=1 next cycle (latency 1); state stays IDLE.
    - start=1 with an iterative cmd: operands latched; state goes to MULT or DIVD; busy=1 from the next cycle.
  - MULT: radix-2 shift-add on operand magnitudes, one bit per cycle, WIDTH iterations.
    - Signed MUL: the 2*WIDTH product is negated if sign(val1)^sign(val2).
  - DIVD: restoring division on magnitudes, one quotient bit per cycle, WIDTH iterations.
    - Signed DIV truncates toward zero; remainder takes the dividend's sign.
  - After the last iteration: state goes to IDLE, busy=0, done=1 in the same cycle.
    - Start at cycle N gives done at cycle N+WIDTH+1 (33 for WIDTH=32).
- done: high for exactly one cycle per accepted op. It is low on all other cycles, including the cycle of an accept.
- Outputs result, result_hi and div_by_zero hold their values until the next done.
- Handshake:
  - start while busy=1 is ignored; no queueing, and the current op is unaffected.
  - start in the same cycle done=1 is accepted (busy=0 then), giving back-to-back ops.
- Divide by zero: no iteration is skipped; latency is unchanged.
  - result = all ones; result_hi = val1; div_by_zero=1.
- Signed overflow, DIV MIN/-1: result=MIN, result_hi=0, div_by_zero=0.
- MULU/DIVU treat operands as unsigned. MUL/DIV treat them as two's complement.
- No X propagation: unused command paths drive 0.

Test Plan:
- Reset, then SUB with val1=0, val2=1546, start at cycle 0 -> done at cycle 1; result=0xFFFFF9F6, result_hi=0, busy never 1.
- MUL with val1=-3, val2=7 -> busy cycles 1..32; done at cycle 33; result=0xFFFFFFEB, result_hi=0xFFFFFFFF. Then MULU 0xFFFFFFFF*2 -> result=0xFFFFFFFE, result_hi=1.
- DIVU 100/7 -> result=14, result_hi=2. DIV -7/2 -> result=0xFFFFFFFD, result_hi=0xFFFFFFFF, done 33 cycles after start.
- DIVU 5/0 -> result=0xFFFFFFFF, result_hi=5, div_by_zero=1. Then DIV 0x80000000/0xFFFFFFFF -> result=0x80000000, result_hi=0, div_by_zero=0.
- Shifts:
  - SLL val1=1, val2=33 -> result=2.
  - SRA 0xFFFFF9F6 by 2 -> 0xFFFFFE7D.
  - SRL same operands -> 0x3FFFFE7D.
- Start MUL, pulse start with ADD at cycle 5 (ignored); drive rst=0 at cycle 10 -> busy=0 and outputs 0 at cycle 11, no done ever. After release, ADD 2+3 -> done next cycle, result=5.
